config_write_controller: RTL and testbench

//  Byte-stream front end that drives the phase-step configuration write port
//  (WriteEnable/WriteAddr/WriteData) of the phase accumulation stage.

---
 rtl/config_write_controller.sv | 157 +++++++++++++++
 tb/tb_config_write_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/config_write_controller.sv
// Decodes framed CMD/ADDR/DATA_HI/DATA_LO byte packets into single-cycle phase-step config writes.
// Optional CONFIG_WRITE_BURST_EN: extra byte pairs in the same frame write to consecutive addresses.
module config_write_controller #(
  parameter int NUM_VOICE_OPERATORS = 32,
  parameter int ADDR_WIDTH          = 5
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_FrameActive,
  input  logic                  i_RxByteValid,
  input  logic [7:0]            i_RxByte,
  output logic                  o_ConfigWriteEnable,
  output logic [ADDR_WIDTH-1:0] o_ConfigWriteAddr,
  output logic [15:0]           o_ConfigWriteData,
  output logic                  o_Busy,
  output logic                  o_Error
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_DHI      = 3'd2;
  localparam logic [2:0] S_DLO      = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
`ifdef CONFIG_WRITE_BURST_EN
  localparam logic [2:0] S_BURST_HI = 3'd5;
  localparam logic [2:0] S_BURST_LO = 3'd6;
`endif

  localparam logic [7:0] CMD_WRITE_STEP = 8'h01;
  localparam logic [8:0] NUM_OPS        = 9'(NUM_VOICE_OPERATORS);

  logic [2:0]            state_q, state_d;
  logic                  frame_q;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_hi_q, data_hi_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;

  logic accept;
  logic frame_rise;
  assign accept     = i_RxByteValid & i_FrameActive;
  assign frame_rise = i_FrameActive & ~frame_q;

`ifdef CONFIG_WRITE_BURST_EN
  logic [8:0] next_addr_ext;
  assign next_addr_ext = 9'(addr_q) + 9'd1;
`endif

  // Packet fields are staged in addr_q/data_hi_q so the write outputs only change on a write.
  always_comb begin
    state_d   = state_q;
    error_d   = error_q;
    addr_d    = addr_q;
    data_hi_d = data_hi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (frame_rise) begin
      error_d = 1'b0;
    end

    if (!i_FrameActive) begin
      state_d = S_IDLE;
    end else if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (i_RxByte == CMD_WRITE_STEP) begin
            state_d = S_ADDR;
          end else begin
            error_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
        S_ADDR: begin
          if ({1'b0, i_RxByte} >= NUM_OPS) begin
            error_d = 1'b1;
            state_d = S_DRAIN;
          end else begin
            addr_d  = i_RxByte[ADDR_WIDTH-1:0];
            state_d = S_DHI;
          end
        end
        S_DHI: begin
          data_hi_d = i_RxByte;
          state_d   = S_DLO;
        end
        S_DLO: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {data_hi_q, i_RxByte};
`ifdef CONFIG_WRITE_BURST_EN
          state_d   = S_BURST_HI;
`else
          state_d   = S_IDLE;
`endif
        end
        S_DRAIN: begin
          state_d = S_DRAIN;
        end
`ifdef CONFIG_WRITE_BURST_EN
        // No wrap-around: running past the last operator rejects the rest of the frame.
        S_BURST_HI: begin
          if (next_addr_ext >= NUM_OPS) begin
            error_d = 1'b1;
            state_d = S_DRAIN;
          end else begin
            addr_d    = ADDR_WIDTH'(next_addr_ext);
            data_hi_d = i_RxByte;
            state_d   = S_BURST_LO;
          end
        end
        S_BURST_LO: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {data_hi_q, i_RxByte};
          state_d   = S_BURST_HI;
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      frame_q   <= 1'b0;
      error_q   <= 1'b0;
      addr_q    <= '0;
      data_hi_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= i_FrameActive;
      error_q   <= error_d;
      addr_q    <= addr_d;
      data_hi_q <= data_hi_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_ConfigWriteEnable = wr_en_q;
  assign o_ConfigWriteAddr   = wr_addr_q;
  assign o_ConfigWriteData   = wr_data_q;
  assign o_Busy              = (state_q != S_IDLE);
  assign o_Error             = error_q;

endmodule

// File: tb/tb_config_write_controller.sv
// Scoreboard bench for config_write_controller: stimulus queues expected writes, a negedge monitor checks them.
module tb_config_write_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        we;
  logic [4:0]  waddr;
  logic [15:0] wdata;
  logic        busy;
  logic        err;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  config_write_controller #(
    .NUM_VOICE_OPERATORS(32),
    .ADDR_WIDTH(5)
  ) dut (
    .i_Clock            (clk),
    .i_Reset            (rst),
    .i_FrameActive      (frame),
    .i_RxByteValid      (valid),
    .i_RxByte           (rx_byte),
    .o_ConfigWriteEnable(we),
    .o_ConfigWriteAddr  (waddr),
    .o_ConfigWriteData  (wdata),
    .o_Busy             (busy),
    .o_Error            (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid   = 1'b1;
    rx_byte = b;
  endtask

  task automatic gap();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic set_frame(input logic v);
    @(negedge clk);
    valid = 1'b0;
    frame = v;
  endtask

  // Called right after the DLO byte is driven; strobe is due after the accepting edge.
  task automatic expect_write(input logic [4:0] a, input logic [15:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
    $display("expect write addr=%0d data=0x%04h at cycle %0d", a, d, e.cyc);
  endtask

  always @(negedge clk) begin
    if (!rst && we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("write seen addr=%0d data=0x%04h cycle %0d", waddr, wdata, cyc);
        check("write_addr", int'(waddr), int'(e.addr));
        check("write_data", int'(wdata), int'(e.data));
        check("write_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_we", int'(we), 0);
    check("reset_addr", int'(waddr), 0);
    check("reset_data", int'(wdata), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_error", int'(err), 0);
    rst = 1'b0;
    gap();

    // 1: single write
    set_frame(1'b1);
    send(8'h01); send(8'h05); send(8'h12); send(8'h34);
    expect_write(5'd5, 16'h1234);
    gap(); gap();
    check("t1_error", int'(err), 0);
    check("t1_busy", int'(busy), 0);
    set_frame(1'b0);

    // 2: bad command, error sticky until next frame opens
    set_frame(1'b1);
    send(8'h7F); send(8'h05); send(8'h12); send(8'h34);
    gap();
    check("t2_error_set", int'(err), 1);
    check("t2_busy_drain", int'(busy), 1);
    set_frame(1'b0);
    gap();
    check("t2_error_sticky", int'(err), 1);
    check("t2_busy_idle", int'(busy), 0);
    set_frame(1'b1);
    gap();
    check("t2_error_cleared", int'(err), 0);
    send(8'h01); send(8'h00); send(8'h00); send(8'h01);
    expect_write(5'd0, 16'h0001);
    gap(); gap();
    set_frame(1'b0);

    // 3: address out of range, then highest legal address
    set_frame(1'b1);
    send(8'h01); send(8'h20); send(8'hAA); send(8'hBB);
    gap();
    check("t3_error_set", int'(err), 1);
    set_frame(1'b0);
    set_frame(1'b1);
    send(8'h01); send(8'h1F); send(8'hFF); send(8'hFF);
    expect_write(5'd31, 16'hFFFF);
    gap(); gap();
    check("t3_error_clear", int'(err), 0);
    set_frame(1'b0);

    // 4: abort mid-packet
    set_frame(1'b1);
    send(8'h01); send(8'h03); send(8'h12);
    set_frame(1'b0);
    gap();
    check("t4_busy", int'(busy), 0);
    check("t4_error", int'(err), 0);
    set_frame(1'b1);
    send(8'h01); send(8'h03); send(8'h56); send(8'h78);
    expect_write(5'd3, 16'h5678);
    gap(); gap();
    set_frame(1'b0);

    // 5: reset mid-packet clears outputs immediately
    set_frame(1'b1);
    send(8'h01); send(8'h03);
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_busy", int'(busy), 0);
    check("t5_addr", int'(waddr), 0);
    check("t5_data", int'(wdata), 0);
    check("t5_we", int'(we), 0);
    check("t5_error", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h01); send(8'h0A); send(8'hBE); send(8'hEF);
    expect_write(5'd10, 16'hBEEF);
    gap(); gap();
    set_frame(1'b0);

`ifndef CONFIG_WRITE_BURST_EN
    // back-to-back packets in one frame: next CMD lands on the strobe cycle
    set_frame(1'b1);
    send(8'h01); send(8'h02); send(8'hAB); send(8'hCD);
    expect_write(5'd2, 16'hABCD);
    send(8'h01); send(8'h04); send(8'h11); send(8'h22);
    expect_write(5'd4, 16'h1122);
    gap(); gap();
    check("b2b_error", int'(err), 0);
    set_frame(1'b0);
`endif

    // 6: burst near the top of the address space
    set_frame(1'b1);
    send(8'h01); send(8'h1E); send(8'h00); send(8'h01);
    expect_write(5'd30, 16'h0001);
    send(8'h00); send(8'h02);
`ifdef CONFIG_WRITE_BURST_EN
    expect_write(5'd31, 16'h0002);
`endif
    send(8'h00); send(8'h03);
    gap(); gap();
    check("t6_error", int'(err), 1);
    check("t6_busy", int'(busy), 1);
    set_frame(1'b0);

    repeat (5) gap();
    check("pending_writes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
